wr_burst_ctrl: RTL and testbench

Write-path counterpart of the DDR2 read FIFO. It accepts a user write stream on `wr_clk`, buffers it, and, once `WRITE_BURST` words are held, drives them into the Virtex-5 MIG DDR2 controller as BL4 write commands with incrementing addresses. It sits between the user data source and the MIG application command/write-data FIFOs, in the same clock domain as the MIG user interface.

---
 rtl/ddr2_pkg.sv | 27 ++
 rtl/wr_sync_fifo.sv | 100 ++++++++++
 rtl/wr_burst_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_wr_burst_ctrl.sv | 521 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr2_pkg.sv
// ---------------------------------------------------------------------------
// ddr2_pkg
//   Definitions shared by the DDR2 (Virtex-5 MIG) user-side blocks:
//   - MIG application command codes (write / read)
//   - BL4 column address step applied after each burst-of-4 command
//   - state encoding of the write-burst controller FSM
// ---------------------------------------------------------------------------
package ddr2_pkg;

  // MIG application command codes (app_af_cmd)
  localparam logic [2:0] MIG_CMD_WRITE = 3'b000;
  localparam logic [2:0] MIG_CMD_READ  = 3'b001;

  // One BL4 command covers four column addresses
  localparam int BL4_ADDR_STEP = 4;

  // Write-burst controller states. ST_WAIT is the DATA1-exit stall used
  // while the MIG FIFOs report almost-full between commands of a burst.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_DATA1 = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } wr_state_t;

endpackage

// File: rtl/wr_sync_fifo.sv
// ---------------------------------------------------------------------------
// wr_sync_fifo
//   Single-clock first-word-fall-through FIFO with registered occupancy.
//   rd_data always presents the head word; rd_en pops it.
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   wr_en, wr_data    : write request / word (ignored while full)
//   rd_en, rd_data    : pop request / current head word
//   count             : registered occupancy (0..DEPTH)
//   full              : count == DEPTH
//   almost_full       : count >= AFULL_LEVEL
//   overflow          : sticky, set when a write arrives while full
// ---------------------------------------------------------------------------
module wr_sync_fifo #(
  parameter int DATA_WIDTH  = 128,
  parameter int DEPTH       = 64,
  parameter int AFULL_LEVEL = 56,
  localparam int PTR_W      = $clog2(DEPTH),
  localparam int CNT_W      = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  almost_full,
  output logic                  overflow
);

  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             full_reg;
  logic             almost_full_reg;
  logic             overflow_reg;
  logic             wr_ok;
  logic             rd_ok;

  // The write qualifier uses the registered full flag, so a pop in the same
  // cycle never makes room for a word offered while full.
  assign wr_ok = wr_en && !full_reg;
  assign rd_ok = rd_en && (count_reg != '0);

  always_comb begin
    count_next = count_reg;
    if (wr_ok && !rd_ok) begin
      count_next = count_reg + CNT_W'(1);
    end else if (!wr_ok && rd_ok) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      full_reg        <= 1'b0;
      almost_full_reg <= 1'b0;
      overflow_reg    <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (rd_ok) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg       <= count_next;
      full_reg        <= (count_next == FULL_CNT);
      almost_full_reg <= (count_next >= AFULL_CNT);
      overflow_reg    <= overflow_reg || (wr_en && full_reg);
    end
  end

  // Storage carries no reset; only the pointers define which words are live.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Fall-through head: the controller registers this word on the way out.
  assign rd_data     = mem[rd_ptr_reg];
  assign count       = count_reg;
  assign full        = full_reg;
  assign almost_full = almost_full_reg;
  assign overflow    = overflow_reg;

endmodule

// File: rtl/wr_burst_ctrl.sv
// ---------------------------------------------------------------------------
// wr_burst_ctrl
//   Buffers a user write stream and, once WRITE_BURST words are held, issues
//   them to the Virtex-5 MIG DDR2 controller as BL4 write commands (one
//   command + two data beats each) at incrementing addresses.
//
// Ports
//   wr_clk, reset        : clock, asynchronous active-high reset
//   wr_fifo_in/_vd       : user write word and its valid
//   wr_base_addr         : start address, loaded by wr_addr_load (IDLE only)
//   app_af_afull         : MIG address FIFO almost full
//   app_wdf_afull        : MIG write-data FIFO almost full
//   full, almost_full    : buffer status (almost: >= FIFO_DEPTH-WRITE_BURST)
//   overflow             : sticky, a write was dropped while full
//   burst_done           : one-cycle pulse after each completed burst
//   app_af_wren/cmd/addr : MIG command strobe, code (write), address
//   app_wdf_wren/data    : MIG write-data strobe and word
//   app_wdf_mask_data    : byte mask, constant 0
//   CONTROL              : ChipScope bus (only with WR_BURST_ILA_EN)
//
// Build option
//   WR_BURST_ILA_EN : adds the CONTROL port and an ila_wr_burst core.
// ---------------------------------------------------------------------------
module wr_burst_ctrl
  import ddr2_pkg::*;
#(
  parameter int DATA_WIDTH  = 128,
  parameter int WRITE_BURST = 8,
  parameter int FIFO_DEPTH  = 64,
  parameter int ADDR_WIDTH  = 31
) (
  input  logic                    wr_clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   wr_fifo_in,
  input  logic                    wr_fifo_vd,
  input  logic [ADDR_WIDTH-1:0]   wr_base_addr,
  input  logic                    wr_addr_load,
  input  logic                    app_af_afull,
  input  logic                    app_wdf_afull,
  output logic                    full,
  output logic                    almost_full,
  output logic                    overflow,
  output logic                    burst_done,
  output logic                    app_af_wren,
  output logic [2:0]              app_af_cmd,
  output logic [ADDR_WIDTH-1:0]   app_af_addr,
  output logic                    app_wdf_wren,
  output logic [DATA_WIDTH-1:0]   app_wdf_data,
  output logic [DATA_WIDTH/8-1:0] app_wdf_mask_data
`ifdef WR_BURST_ILA_EN
  ,
  inout  wire  [35:0]             CONTROL
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]      BURST_WORDS    = CNT_W'(WRITE_BURST);
  localparam logic [CNT_W-1:0]      CMDS_PER_BURST = CNT_W'(WRITE_BURST / 2);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP      = ADDR_WIDTH'(BL4_ADDR_STEP);

  wr_state_t state_reg, state_next;

  logic [ADDR_WIDTH-1:0] cur_addr_reg, cur_addr_next;
  logic [CNT_W-1:0]      cmd_cnt_reg, cmd_cnt_next;
  logic                  af_wren_reg, af_wren_next;
  logic [ADDR_WIDTH-1:0] af_addr_reg, af_addr_next;
  logic                  wdf_wren_reg, wdf_wren_next;
  logic [DATA_WIDTH-1:0] wdf_data_reg, wdf_data_next;
  logic                  burst_done_reg, burst_done_next;

  logic                  fifo_pop;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic [CNT_W-1:0]      fifo_count;
  logic                  mig_ready;

  wr_sync_fifo #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DEPTH       (FIFO_DEPTH),
    .AFULL_LEVEL (FIFO_DEPTH - WRITE_BURST)
  ) u_fifo (
    .clk         (wr_clk),
    .rst         (reset),
    .wr_en       (wr_fifo_vd),
    .wr_data     (wr_fifo_in),
    .rd_en       (fifo_pop),
    .rd_data     (fifo_head),
    .count       (fifo_count),
    .full        (full),
    .almost_full (almost_full),
    .overflow    (overflow)
  );

  // Backpressure only gates the step into a command cycle.
  assign mig_ready = !app_af_afull && !app_wdf_afull;

  // Outputs are registered on the edge that enters a state, so the strobes
  // and data for a CMD or DATA1 cycle are valid during that state.
  always_comb begin
    state_next      = state_reg;
    cur_addr_next   = cur_addr_reg;
    cmd_cnt_next    = cmd_cnt_reg;
    af_wren_next    = 1'b0;
    af_addr_next    = af_addr_reg;
    wdf_wren_next   = 1'b0;
    wdf_data_next   = wdf_data_reg;
    burst_done_next = 1'b0;
    fifo_pop        = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (wr_addr_load) begin
          cur_addr_next = wr_base_addr;
        end
        if ((fifo_count >= BURST_WORDS) && mig_ready) begin
          state_next = ST_CMD;
        end
      end
      ST_CMD: begin
        state_next = ST_DATA1;
      end
      ST_DATA1: begin
        if (cmd_cnt_reg == CMDS_PER_BURST) begin
          state_next = ST_DONE;
        end else if (mig_ready) begin
          state_next = ST_CMD;
        end else begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mig_ready) begin
          state_next = ST_CMD;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Entering CMD: command at the (possibly just loaded) address, first beat.
    if (state_next == ST_CMD) begin
      af_wren_next  = 1'b1;
      af_addr_next  = cur_addr_next;
      wdf_wren_next = 1'b1;
      wdf_data_next = fifo_head;
      fifo_pop      = 1'b1;
      cmd_cnt_next  = cmd_cnt_reg + CNT_W'(1);
    end

    // Entering DATA1: second beat, address moves one BL4 step (wraps).
    if (state_next == ST_DATA1) begin
      wdf_wren_next = 1'b1;
      wdf_data_next = fifo_head;
      fifo_pop      = 1'b1;
      cur_addr_next = cur_addr_reg + ADDR_STEP;
    end

    if (state_next == ST_DONE) begin
      burst_done_next = 1'b1;
      cmd_cnt_next    = '0;
    end
  end

  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      cur_addr_reg   <= '0;
      cmd_cnt_reg    <= '0;
      af_wren_reg    <= 1'b0;
      af_addr_reg    <= '0;
      wdf_wren_reg   <= 1'b0;
      wdf_data_reg   <= '0;
      burst_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cur_addr_reg   <= cur_addr_next;
      cmd_cnt_reg    <= cmd_cnt_next;
      af_wren_reg    <= af_wren_next;
      af_addr_reg    <= af_addr_next;
      wdf_wren_reg   <= wdf_wren_next;
      wdf_data_reg   <= wdf_data_next;
      burst_done_reg <= burst_done_next;
    end
  end

  assign burst_done        = burst_done_reg;
  assign app_af_wren       = af_wren_reg;
  assign app_af_cmd        = MIG_CMD_WRITE;
  assign app_af_addr       = af_addr_reg;
  assign app_wdf_wren      = wdf_wren_reg;
  assign app_wdf_data      = wdf_data_reg;
  assign app_wdf_mask_data = '0;

`ifdef WR_BURST_ILA_EN
  logic [130:0] ila_trig0;

  assign ila_trig0 = {wr_fifo_vd, wr_fifo_in[63:0],
                      af_wren_reg, wdf_wren_reg, wdf_data_reg[63:0]};

  ila_wr_burst u_ila (
    .CONTROL (CONTROL),
    .CLK     (wr_clk),
    .TRIG0   (ila_trig0)
  );
`endif

endmodule

// File: tb/tb_wr_burst_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wr_burst_ctrl
//   Self-checking bench for wr_burst_ctrl. A negedge monitor records every
//   command address, data beat and burst_done pulse; each scenario task
//   compares those records with the stream the write-burst rules predict
//   (words leave in arrival order, in groups of WRITE_BURST, at addresses
//   base + 4*k modulo 2^ADDR_WIDTH).
// ---------------------------------------------------------------------------
module tb_wr_burst_ctrl;

  localparam int DW = 128;
  localparam int WB = 8;
  localparam int FD = 64;
  localparam int AW = 31;

  logic            clk = 1'b0;
  logic            reset;
  logic [DW-1:0]   wr_fifo_in;
  logic            wr_fifo_vd;
  logic [AW-1:0]   wr_base_addr;
  logic            wr_addr_load;
  logic            app_af_afull;
  logic            app_wdf_afull;
  logic            full;
  logic            almost_full;
  logic            overflow;
  logic            burst_done;
  logic            app_af_wren;
  logic [2:0]      app_af_cmd;
  logic [AW-1:0]   app_af_addr;
  logic            app_wdf_wren;
  logic [DW-1:0]   app_wdf_data;
  logic [DW/8-1:0] app_wdf_mask_data;

  always #5 clk = ~clk;

  wr_burst_ctrl #(
    .DATA_WIDTH  (DW),
    .WRITE_BURST (WB),
    .FIFO_DEPTH  (FD),
    .ADDR_WIDTH  (AW)
  ) dut (
    .wr_clk            (clk),
    .reset             (reset),
    .wr_fifo_in        (wr_fifo_in),
    .wr_fifo_vd        (wr_fifo_vd),
    .wr_base_addr      (wr_base_addr),
    .wr_addr_load      (wr_addr_load),
    .app_af_afull      (app_af_afull),
    .app_wdf_afull     (app_wdf_afull),
    .full              (full),
    .almost_full       (almost_full),
    .overflow          (overflow),
    .burst_done        (burst_done),
    .app_af_wren       (app_af_wren),
    .app_af_cmd        (app_af_cmd),
    .app_af_addr       (app_af_addr),
    .app_wdf_wren      (app_wdf_wren),
    .app_wdf_data      (app_wdf_data),
    .app_wdf_mask_data (app_wdf_mask_data)
  );

  int tests = 0;
  int fails = 0;

  // Monitor records
  logic [AW-1:0] obs_addr [$];
  logic [DW-1:0] obs_data [$];
  int            obs_done;
  int            afull_viol;
  logic          last_busy;

  // Reference stream: words accepted by the buffer, in order
  logic [DW-1:0] model_q [$];

  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      if (app_af_wren === 1'b1) begin
        obs_addr.push_back(app_af_addr);
        // a command may only follow a cycle with both afull inputs low
        if (last_busy) afull_viol++;
      end
      if (app_wdf_wren === 1'b1) obs_data.push_back(app_wdf_data);
      if (burst_done === 1'b1) obs_done++;
    end
    last_busy = (app_af_afull === 1'b1) || (app_wdf_afull === 1'b1);
  end

  function automatic logic [DW-1:0] rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [DW-1:0] d);
    wr_fifo_in = d;
    wr_fifo_vd = 1'b1;
    model_q.push_back(d);
    tick();
    wr_fifo_vd = 1'b0;
  endtask

  task automatic load_base(input logic [AW-1:0] a);
    wr_base_addr = a;
    wr_addr_load = 1'b1;
    tick();
    wr_addr_load = 1'b0;
  endtask

  task automatic clear_obs();
    obs_addr.delete();
    obs_data.delete();
    model_q.delete();
    obs_done   = 0;
    afull_viol = 0;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    wr_fifo_vd    = 1'b0;
    wr_addr_load  = 1'b0;
    app_af_afull  = 1'b0;
    app_wdf_afull = 1'b0;
    wr_fifo_in    = '0;
    wr_base_addr  = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    clear_obs();
  endtask

  task automatic wait_bursts(input int n, input int budget, output bit timed_out);
    int c = 0;
    timed_out = 1'b0;
    while (obs_done < n) begin
      if (c >= budget) begin
        timed_out = 1'b1;
        break;
      end
      tick();
      c++;
    end
    repeat (3) tick();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    reset         = 1'b1;
    wr_fifo_vd    = 1'b0;
    wr_addr_load  = 1'b0;
    app_af_afull  = 1'b0;
    app_wdf_afull = 1'b0;
    wr_fifo_in    = '0;
    wr_base_addr  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({app_af_wren, app_wdf_wren, burst_done} !== 3'b000) begin
      fails++;
      $display("FAIL reset_strobes: got %b required 000", {app_af_wren, app_wdf_wren, burst_done});
    end
    tests++;
    if ({full, almost_full, overflow} !== 3'b000) begin
      fails++;
      $display("FAIL reset_flags: got %b required 000", {full, almost_full, overflow});
    end
    tests++;
    if (app_af_addr !== '0) begin
      fails++;
      $display("FAIL reset_addr: got %h required 0", app_af_addr);
    end
    tests++;
    if (app_wdf_data !== '0) begin
      fails++;
      $display("FAIL reset_data: got %h required 0", app_wdf_data);
    end
    tests++;
    if (app_af_cmd !== 3'b000 || app_wdf_mask_data !== '0) begin
      fails++;
      $display("FAIL reset_cmd_mask: cmd %b mask %h required 000 / 0", app_af_cmd, app_wdf_mask_data);
    end
    $display("[TB] test_reset done");
    do_reset();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_basic_burst();
    bit to;
    logic [DW-1:0] w;
    do_reset();
    load_base(31'h100);
    for (int i = 1; i <= 8; i++) begin
      w = DW'(i);
      write_word(w);
    end
    wait_bursts(1, 50, to);
    tests++;
    if (to || obs_done != 1 || obs_addr.size() != 4 || obs_data.size() != 8) begin
      fails++;
      $display("FAIL basic_counts: timeout %0d done %0d cmds %0d beats %0d required 0 1 4 8",
               to, obs_done, obs_addr.size(), obs_data.size());
    end
    for (int i = 0; i < 4 && i < obs_addr.size(); i++) begin
      tests++;
      if (obs_addr[i] !== AW'(32'h100 + 4 * i)) begin
        fails++;
        $display("FAIL basic_addr[%0d]: got %h required %h", i, obs_addr[i], AW'(32'h100 + 4 * i));
      end
    end
    for (int i = 0; i < 8 && i < obs_data.size(); i++) begin
      tests++;
      if (obs_data[i] !== DW'(i + 1)) begin
        fails++;
        $display("FAIL basic_data[%0d]: got %h required %h", i, obs_data[i], DW'(i + 1));
      end
    end
    $display("[TB] test_basic_burst: %0d cmds, %0d beats, %0d done", obs_addr.size(), obs_data.size(), obs_done);
  endtask

  // -------------------------------------------------------------------------
  task automatic test_latency();
    bit to;
    do_reset();
    load_base('0);
    for (int i = 0; i < 7; i++) write_word(rand_word());
    repeat (10) tick();
    tests++;
    if (obs_addr.size() != 0) begin
      fails++;
      $display("FAIL seven_words_no_cmd: got %0d commands required 0", obs_addr.size());
    end
    // 8th word is written at the next edge; the command must follow one cycle later
    wr_fifo_in = rand_word();
    model_q.push_back(wr_fifo_in);
    wr_fifo_vd = 1'b1;
    @(posedge clk);
    #1 wr_fifo_vd = 1'b0;
    @(negedge clk);
    tests++;
    if (app_af_wren !== 1'b0) begin
      fails++;
      $display("FAIL latency_early: app_af_wren got %b required 0", app_af_wren);
    end
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (app_af_wren !== 1'b1 || app_af_addr !== '0) begin
      fails++;
      $display("FAIL latency_cmd: app_af_wren %b addr %h required 1 / 0", app_af_wren, app_af_addr);
    end
    @(posedge clk);
    #1;
    wait_bursts(1, 50, to);
    tests++;
    if (to || obs_data.size() != 8 || obs_data != model_q) begin
      fails++;
      $display("FAIL latency_data: timeout %0d beats %0d required 0 / 8 matching words", to, obs_data.size());
    end
    $display("[TB] test_latency: %0d beats after 8th word", obs_data.size());
  endtask

  // -------------------------------------------------------------------------
  task automatic test_backpressure();
    bit to;
    int c;
    logic [AW-1:0] base;
    do_reset();
    base = AW'($urandom());
    base[1:0] = 2'b00;
    load_base(base);
    for (int i = 0; i < 8; i++) write_word(rand_word());
    c = 0;
    while (app_af_wren !== 1'b1 && c < 50) begin
      @(negedge clk);
      c++;
    end
    tests++;
    if (c >= 50) begin
      fails++;
      $display("FAIL bp_first_cmd: no command within 50 cycles, required one");
    end
    app_af_afull = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (app_wdf_wren !== 1'b1 || app_af_wren !== 1'b0) begin
      fails++;
      $display("FAIL bp_data1_completes: wdf_wren %b af_wren %b required 1 / 0", app_wdf_wren, app_af_wren);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      tests++;
      if (app_af_wren !== 1'b0 || app_wdf_wren !== 1'b0) begin
        fails++;
        $display("FAIL bp_stall[%0d]: af_wren %b wdf_wren %b required 0 / 0", i, app_af_wren, app_wdf_wren);
      end
    end
    @(posedge clk);
    #1 app_af_afull = 1'b0;
    wait_bursts(1, 50, to);
    tests++;
    if (to || obs_addr.size() != 4 || afull_viol != 0) begin
      fails++;
      $display("FAIL bp_cmds: timeout %0d cmds %0d afull_violations %0d required 0 4 0",
               to, obs_addr.size(), afull_viol);
    end
    for (int i = 0; i < obs_addr.size() && i < 4; i++) begin
      tests++;
      if (obs_addr[i] !== base + AW'(4 * i)) begin
        fails++;
        $display("FAIL bp_addr[%0d]: got %h required %h", i, obs_addr[i], base + AW'(4 * i));
      end
    end
    tests++;
    if (obs_data != model_q) begin
      fails++;
      $display("FAIL bp_data: got %0d beats, stream differs from the 8 written words", obs_data.size());
    end
    $display("[TB] test_backpressure: base %h, %0d cmds, %0d beats", base, obs_addr.size(), obs_data.size());
  endtask

  // -------------------------------------------------------------------------
  task automatic test_overflow();
    bit to;
    logic [2:0] exp_flags;
    logic [DW-1:0] w;
    do_reset();
    app_af_afull  = 1'b1;
    app_wdf_afull = 1'b1;
    for (int k = 1; k <= 65; k++) begin
      w = rand_word();
      wr_fifo_in = w;
      wr_fifo_vd = 1'b1;
      if (k <= FD) model_q.push_back(w);
      tick();
      wr_fifo_vd = 1'b0;
      exp_flags = {k >= FD, k >= FD - WB, k > FD};
      tests++;
      if ({full, almost_full, overflow} !== exp_flags) begin
        fails++;
        $display("FAIL ovf_flags[%0d]: full/afull/ovf got %b required %b", k, {full, almost_full, overflow}, exp_flags);
      end
    end
    tests++;
    if (obs_addr.size() != 0) begin
      fails++;
      $display("FAIL ovf_no_cmd: got %0d commands while afull high, required 0", obs_addr.size());
    end
    app_af_afull  = 1'b0;
    app_wdf_afull = 1'b0;
    wait_bursts(FD / WB, 300, to);
    tests++;
    if (to || obs_data.size() != FD || obs_data != model_q) begin
      fails++;
      $display("FAIL ovf_drain: timeout %0d beats %0d required 0 / 64 matching words", to, obs_data.size());
    end
    tests++;
    if (overflow !== 1'b1 || full !== 1'b0) begin
      fails++;
      $display("FAIL ovf_sticky: overflow %b full %b required 1 / 0", overflow, full);
    end
    $display("[TB] test_overflow: %0d beats drained, overflow %b", obs_data.size(), overflow);
  endtask

  // -------------------------------------------------------------------------
  task automatic test_wrap();
    bit to;
    logic [AW-1:0] base;
    do_reset();
    base = 31'h7FFFFFFC;
    load_base(base);
    for (int i = 0; i < 8; i++) write_word(rand_word());
    wait_bursts(1, 50, to);
    tests++;
    if (to || obs_addr.size() != 4 || obs_data != model_q) begin
      fails++;
      $display("FAIL wrap_counts: timeout %0d cmds %0d required 0 / 4 with matching data", to, obs_addr.size());
    end
    for (int i = 0; i < obs_addr.size() && i < 4; i++) begin
      tests++;
      if (obs_addr[i] !== base + AW'(4 * i)) begin
        fails++;
        $display("FAIL wrap_addr[%0d]: got %h required %h", i, obs_addr[i], base + AW'(4 * i));
      end
    end
    $display("[TB] test_wrap: %0d cmds from %h", obs_addr.size(), base);
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset_mid_burst();
    bit to;
    int beats;
    int c;
    do_reset();
    load_base(31'h200);
    for (int i = 0; i < 8; i++) write_word(rand_word());
    beats = 0;
    c = 0;
    while (beats < 4 && c < 50) begin
      @(negedge clk);
      if (app_wdf_wren === 1'b1) beats++;
      c++;
    end
    tests++;
    if (beats != 4) begin
      fails++;
      $display("FAIL rst_mid_reach: saw %0d beats required 4", beats);
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({app_af_wren, app_wdf_wren, burst_done, full, almost_full, overflow} !== 6'b0) begin
      fails++;
      $display("FAIL rst_mid_flags: got %b required 000000",
               {app_af_wren, app_wdf_wren, burst_done, full, almost_full, overflow});
    end
    tests++;
    if (app_af_addr !== '0 || app_wdf_data !== '0) begin
      fails++;
      $display("FAIL rst_mid_regs: addr %h data %h required 0 / 0", app_af_addr, app_wdf_data);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    clear_obs();
    for (int i = 0; i < 8; i++) write_word(rand_word());
    wait_bursts(1, 50, to);
    repeat (10) tick();
    tests++;
    if (to || obs_done != 1 || obs_addr.size() != 4 || obs_data != model_q) begin
      fails++;
      $display("FAIL rst_mid_next: timeout %0d done %0d cmds %0d required 0 1 4 with only new words",
               to, obs_done, obs_addr.size());
    end
    for (int i = 0; i < obs_addr.size() && i < 4; i++) begin
      tests++;
      if (obs_addr[i] !== AW'(4 * i)) begin
        fails++;
        $display("FAIL rst_mid_addr[%0d]: got %h required %h", i, obs_addr[i], AW'(4 * i));
      end
    end
    $display("[TB] test_reset_mid_burst: next burst %0d cmds", obs_addr.size());
  endtask

  // -------------------------------------------------------------------------
  task automatic test_random_stream();
    bit to;
    int n_bursts;
    logic [AW-1:0] base;
    logic [DW-1:0] exp_stream [$];
    do_reset();
    base = AW'($urandom());
    base[1:0] = 2'b00;
    load_base(base);
    for (int cyc = 0; cyc < 300; cyc++) begin
      wr_fifo_vd    = ($urandom_range(0, 2) == 0);
      wr_fifo_in    = rand_word();
      app_af_afull  = ($urandom_range(0, 3) == 0);
      app_wdf_afull = ($urandom_range(0, 4) == 0);
      if (wr_fifo_vd) model_q.push_back(wr_fifo_in);
      tick();
    end
    wr_fifo_vd    = 1'b0;
    app_af_afull  = 1'b0;
    app_wdf_afull = 1'b0;
    n_bursts = model_q.size() / WB;
    for (int i = 0; i < n_bursts * WB; i++) exp_stream.push_back(model_q[i]);
    wait_bursts(n_bursts, 600, to);
    repeat (10) tick();
    tests++;
    if (to || obs_done != n_bursts || overflow !== 1'b0) begin
      fails++;
      $display("FAIL rand_bursts: timeout %0d done %0d overflow %b required 0 %0d 0",
               to, obs_done, overflow, n_bursts);
    end
    tests++;
    if (obs_data != exp_stream) begin
      fails++;
      $display("FAIL rand_data: got %0d beats required %0d in write order", obs_data.size(), exp_stream.size());
    end
    tests++;
    if (obs_addr.size() != n_bursts * WB / 2 || afull_viol != 0) begin
      fails++;
      $display("FAIL rand_cmds: cmds %0d afull_violations %0d required %0d 0",
               obs_addr.size(), afull_viol, n_bursts * WB / 2);
    end
    for (int i = 0; i < obs_addr.size(); i++) begin
      tests++;
      if (obs_addr[i] !== base + AW'(4 * i)) begin
        fails++;
        $display("FAIL rand_addr[%0d]: got %h required %h", i, obs_addr[i], base + AW'(4 * i));
      end
    end
    $display("[TB] test_random_stream: %0d words, %0d bursts, %0d cmds", model_q.size(), n_bursts, obs_addr.size());
  endtask

  // -------------------------------------------------------------------------
  initial begin
    reset = 1'b1;
    test_reset();
    test_basic_burst();
    test_latency();
    test_backpressure();
    test_overflow();
    test_wrap();
    test_reset_mid_burst();
    test_random_stream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute bound on simulated time
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded 200000 time units, required completion");
    $fatal(1);
  end

endmodule
